program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 11 +
 rtl/program_loader.sv | 87 ++++++++
 tb/tb_program_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction ROM write port out.
interface program_loader_if #(parameter int ADDR_WIDTH = 12);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  rom_we;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [15:0]           rom_data;
    modport master (input rx_data, rx_valid, output rx_ready, rom_we, rom_addr, rom_data);
    modport slave (output rx_data, rx_valid, input rx_ready, rom_we, rom_addr, rom_data);
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a framed, checksummed program over a byte stream
// and writes it into instruction ROM while holding the CPU in reset.
module program_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.master  bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] idle_cnt;
    logic [7:0]    sum, sum_nx, len_hi, data_hi;
    logic [15:0]   idx, last;
    logic [16:0]   len;
    logic          ready, acc, loading, tmo;

    assign acc          = bus.rx_valid & ready;
    assign loading      = !(state inside {IDLE, DONE, ERROR});
    assign tmo          = loading && idle_cnt == CW'(TIMEOUT);
    assign sum_nx       = sum + bus.rx_data;
    assign len          = {1'b0, len_hi, bus.rx_data};
    assign bus.rx_ready = ready;
    assign cpu_hold     = !(state inside {IDLE, DONE});
    assign done         = state == DONE;
    assign error        = state == ERROR;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // An accepted byte always wins over a timeout expiring on the same edge.
    always_comb begin
        state_nx = state;
        if (acc)
            case (state)
                IDLE, DONE, ERROR: state_nx = bus.rx_data == 8'hA5 ? LEN_HI : state;
                LEN_HI:  state_nx = LEN_LO;
                LEN_LO:  state_nx = (len == 17'd0 || len > 17'(2**ADDR_WIDTH)) ? ERROR : DATA_HI;
                DATA_HI: state_nx = DATA_LO;
                DATA_LO: state_nx = idx == last ? CHECK : DATA_HI;
                CHECK:   state_nx = sum_nx == 8'h00 ? DONE : ERROR;
                default: state_nx = state;
            endcase
        else if (tmo)
            state_nx = ERROR;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            ready        <= 1'b0;
            idle_cnt     <= '0;
            sum          <= '0;
            len_hi       <= '0;
            data_hi      <= '0;
            idx          <= '0;
            last         <= '0;
            bus.rom_we   <= 1'b0;
            bus.rom_addr <= '0;
            bus.rom_data <= '0;
        end else begin
            ready      <= 1'b1;
            bus.rom_we <= 1'b0;
            idle_cnt   <= (acc || !loading) ? '0 : idle_cnt + CW'(1);
            if (acc && !loading && bus.rx_data == 8'hA5) begin
                sum <= '0;
                idx <= '0;
            end else if (acc && loading) begin
                sum <= sum_nx;
                if (state == LEN_HI) len_hi <= bus.rx_data;
                if (state == LEN_LO) last <= len[15:0] - 16'd1;
                if (state == DATA_HI) data_hi <= bus.rx_data;
                if (state == DATA_LO) begin
                    bus.rom_we   <= 1'b1;
                    bus.rom_data <= {data_hi, bus.rx_data};
                    bus.rom_addr <= idx[ADDR_WIDTH-1:0];
                    idx          <= idx + 16'd1;
                end
            end
        end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard-driven checks of framing, checksum, length,
// timeout and reset behaviour of program_loader.
module tb_program_loader;
    localparam int AW = 12;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold, done, error;
    int checks = 0;
    int passed = 0;
    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] mon_e;
    logic [15:0] words[$];

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus();

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always @(negedge clk)
        if (reset && bus.rom_we) begin
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL rom_write unexpected: got addr=%h data=%h, required no write", bus.rom_addr, bus.rom_data);
            else begin
                mon_e = exp_q.pop_front();
                if ({bus.rom_addr, bus.rom_data} !== mon_e)
                    $display("FAIL rom_write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.rom_addr, bus.rom_data, mon_e[AW+15:16], mon_e[15:0]);
                else passed++;
            end
        end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        while (rnd && $urandom_range(1) == 0) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic run_load(input string name, input bit bad, input bit rnd);
        logic [15:0] n;
        logic [7:0] s;
        n = 16'(words.size());
        s = n[15:8] + n[7:0];
        send_byte(8'hA5, rnd);
        checks++;
        if ({done, error, cpu_hold} !== 3'b001)
            $display("FAIL %s start: got done/error/hold=%b, required 001", name, {done, error, cpu_hold});
        else passed++;
        send_byte(n[15:8], rnd);
        send_byte(n[7:0], rnd);
        foreach (words[i]) begin
            exp_q.push_back({AW'(i), words[i]});
            s = s + words[i][15:8] + words[i][7:0];
            send_byte(words[i][15:8], rnd);
            send_byte(words[i][7:0], rnd);
        end
        s = ~s + 8'd1 + {7'd0, bad};
        send_byte(s, rnd);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s writes: got %0d writes missing, required 0", name, exp_q.size());
        else passed++;
        exp_q.delete();
        checks++;
        if ({done, error, cpu_hold} !== (bad ? 3'b011 : 3'b100))
            $display("FAIL %s result: got done/error/hold=%b, required %b", name, {done, error, cpu_hold}, bad ? 3'b011 : 3'b100);
        else passed++;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #2;
        checks++;
        if ({bus.rx_ready, bus.rom_we, bus.rom_addr, bus.rom_data, cpu_hold, done, error} !== '0)
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                     bus.rx_ready, bus.rom_we, bus.rom_addr, bus.rom_data, cpu_hold, done, error);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.rx_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b, required 1", bus.rx_ready);
        else passed++;
    endtask

    task automatic test_good_load();
        words = '{16'h1234, 16'hABCD};
        run_load("good_load", 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        words = '{16'h1234, 16'hABCD};
        run_load("bad_checksum", 1'b1, 1'b0);
    endtask

    task automatic test_bad_length(input string name, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(8'hA5, 1'b0);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        repeat (4) @(posedge clk); #1;
        checks++;
        if ({done, error, cpu_hold} !== 3'b011)
            $display("FAIL %s: got done/error/hold=%b, required 011", name, {done, error, cpu_hold});
        else passed++;
    endtask

    task automatic test_max_len();
        words.delete();
        for (int i = 0; i < (1 << AW); i++) words.push_back(16'($urandom));
        run_load("max_len", 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TO - 5) @(posedge clk); #1;
        checks++;
        if ({done, error, cpu_hold} !== 3'b001)
            $display("FAIL timeout_early: got done/error/hold=%b, required 001", {done, error, cpu_hold});
        else passed++;
        repeat (10) @(posedge clk); #1;
        checks++;
        if ({done, error, cpu_hold} !== 3'b011)
            $display("FAIL timeout_expired: got done/error/hold=%b, required 011", {done, error, cpu_hold});
        else passed++;
        words = '{16'hBEEF};
        run_load("after_timeout", 1'b0, 1'b0);
    endtask

    task automatic test_timeout_edge();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TO) @(posedge clk); #1;
        exp_q.push_back({AW'(0), 16'h1234});
        send_byte(8'h34, 1'b0);
        send_byte(8'hB9, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL timeout_edge_write: got %0d writes missing, required 0", exp_q.size());
        else passed++;
        exp_q.delete();
        checks++;
        if ({done, error, cpu_hold} !== 3'b100)
            $display("FAIL timeout_edge_result: got done/error/hold=%b, required 100", {done, error, cpu_hold});
        else passed++;
    endtask

    task automatic test_random_valid();
        words = '{16'h1234, 16'hABCD};
        run_load("random_valid", 1'b0, 1'b1);
    endtask

    task automatic test_reset_midload();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.rx_ready, bus.rom_we, bus.rom_addr, bus.rom_data, cpu_hold, done, error} !== '0)
            $display("FAIL midload_reset: got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b, required all 0",
                     bus.rx_ready, bus.rom_we, bus.rom_addr, bus.rom_data, cpu_hold, done, error);
        else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({done, error, cpu_hold} !== 3'b000)
            $display("FAIL midload_after: got done/error/hold=%b, required 000", {done, error, cpu_hold});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_length("len_zero", 8'h00, 8'h00);
        test_bad_length("len_too_big", 8'h10, 8'h01);
        test_max_len();
        test_timeout();
        test_timeout_edge();
        test_random_valid();
        test_reset_midload();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
